// File: rtl/cordic_pkg.sv
// Shared constants and types for the CORDIC rotation pipeline and its request scheduler.
package cordic_pkg;

  localparam int DATA_W         = 16;
  localparam int INT_W          = 7;
  localparam int FRAC_W         = 8;
  localparam int CORDIC_LATENCY = 6;
  // Widest requester ID supported (16 requesters); narrower IDs are zero-extended.
  localparam int MAX_ID_W       = 4;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [DATA_W-1:0]   x;
    logic [DATA_W-1:0]   y;
    logic [DATA_W-1:0]   degree;
  } resp_entry_t;

  localparam int RESP_W = $bits(resp_entry_t);

endpackage

// File: rtl/cordic_resp_fifo.sv
// Synchronous response FIFO with explicit occupancy counter; pointers wrap modulo DEPTH.
module cordic_resp_fifo
  import cordic_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [RESP_W-1:0] push_data,
  input  logic              pop,
  output logic [RESP_W-1:0] head,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [RESP_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd_ptr];
  assign count  = r_count;

  // NOTE: storage is not reset; r_count gates every read, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  push_not_full_a: assert property (@(posedge clk) disable iff (!reset) push |-> !full);

endmodule

// File: rtl/cordic_req_scheduler.sv
// Round-robin scheduler sharing one non-stallable CORDIC pipeline among NUM_REQ requesters.
// Optional per-requester statistics are enabled with the CORDIC_SCHED_STATS_EN macro.
module cordic_req_scheduler
  import cordic_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int LATENCY    = CORDIC_LATENCY,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_angle,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         pipe_degree_in,
  input  logic [DATA_W-1:0]         pipe_x,
  input  logic [DATA_W-1:0]         pipe_y,
  input  logic [DATA_W-1:0]         pipe_degree,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_x,
  output logic [DATA_W-1:0]         resp_y,
  output logic [DATA_W-1:0]         resp_degree,
  output logic                      busy
`ifdef CORDIC_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stat_issued,
  output logic [15:0]               stat_stall
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]  r_outstanding;
  logic [LATENCY:0]  r_tag_valid;
  logic [ID_W-1:0]   r_tag_id [LATENCY+1];
  logic [DATA_W-1:0] r_pipe_degree_in;

  logic              w_win_found;
  logic [ID_W-1:0]   w_win_id;
  logic              w_issue_ok;
  logic              w_transfer;
  logic              w_pop;
  resp_entry_t       w_push_entry;
  resp_entry_t       w_head_entry;
  logic [RESP_W-1:0] w_head;
  logic [CNT_W-1:0]  w_fifo_count;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_unused;

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    int idx;
    w_win_found = 1'b0;
    w_win_id    = '0;
    idx         = 0;
    // Walk from farthest to nearest so the requester closest to r_rr_ptr is written last.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(r_rr_ptr) + i) % NUM_REQ;
      if (req_valid[idx]) begin
        w_win_found = 1'b1;
        w_win_id    = ID_W'(idx);
      end
    end
  end

  // A pop this cycle frees its credit immediately, so issue may refill it at once.
  assign w_pop      = resp_valid && resp_ready;
  assign w_issue_ok = (r_outstanding < CNT_W'(FIFO_DEPTH)) || w_pop;
  assign w_transfer = reset && w_win_found && w_issue_ok;
  assign req_ready  = w_transfer ? (NUM_REQ'(1) << w_win_id) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr         <= '0;
      r_pipe_degree_in <= '0;
      r_outstanding    <= '0;
      r_tag_valid      <= '0;
      for (int s = 0; s <= LATENCY; s++) r_tag_id[s] <= '0;
    end else begin
      r_tag_valid <= {r_tag_valid[LATENCY-1:0], w_transfer};
      r_tag_id[0] <= w_win_id;
      for (int s = 1; s <= LATENCY; s++) r_tag_id[s] <= r_tag_id[s-1];
      if (w_transfer) begin
        r_rr_ptr         <= (w_win_id == ID_W'(NUM_REQ - 1)) ? '0 : w_win_id + 1'b1;
        r_pipe_degree_in <= req_angle[int'(w_win_id)*DATA_W +: DATA_W];
      end
      case ({w_transfer, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  assign w_push_entry = '{id:     MAX_ID_W'(r_tag_id[LATENCY]),
                          x:      pipe_x,
                          y:      pipe_y,
                          degree: pipe_degree};

  cordic_resp_fifo #(.DEPTH(FIFO_DEPTH)) u_resp_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (r_tag_valid[LATENCY]),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_fifo_count),
    .full      (w_fifo_full),
    .empty     (w_fifo_empty)
  );

  // The head word is forced to zero when empty so the response bus is quiet at idle.
  assign w_head_entry   = resp_entry_t'(w_head);
  assign resp_valid     = !w_fifo_empty;
  assign resp_id        = resp_valid ? w_head_entry.id[ID_W-1:0] : '0;
  assign resp_x         = resp_valid ? w_head_entry.x            : '0;
  assign resp_y         = resp_valid ? w_head_entry.y            : '0;
  assign resp_degree    = resp_valid ? w_head_entry.degree       : '0;
  assign pipe_degree_in = r_pipe_degree_in;
  assign busy           = (|r_tag_valid) || !w_fifo_empty;
  assign w_unused       = ^{w_head_entry.id, w_fifo_count, w_fifo_full};

`ifdef CORDIC_SCHED_STATS_EN
  logic [15:0] r_stat_issued [NUM_REQ];
  logic [15:0] r_stat_stall;
  logic        w_stall;

  assign w_stall = (|req_valid) && !w_issue_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < NUM_REQ; k++) r_stat_issued[k] <= '0;
      r_stat_stall <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w_transfer && (w_win_id == ID_W'(k)) && (r_stat_issued[k] != 16'hFFFF))
          r_stat_issued[k] <= r_stat_issued[k] + 1'b1;
      end
      if (w_stall && (r_stat_stall != 16'hFFFF)) r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat
    assign stat_issued[k*16 +: 16] = r_stat_issued[k];
  end
  assign stat_stall = r_stat_stall;
`endif

endmodule

// File: tb/tb_cordic_req_scheduler.sv
// Directed bench for cordic_req_scheduler with a stub fixed-latency pipeline and a response scoreboard.
`timescale 1ns/1ps
module tb_cordic_req_scheduler;
  import cordic_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int LAT     = CORDIC_LATENCY;
  localparam int DEPTH   = 8;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*DATA_W-1:0] req_angle = '0;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         pipe_degree_in;
  logic [DATA_W-1:0]         pipe_x, pipe_y, pipe_degree;
  logic                      resp_valid;
  logic                      resp_ready = 1'b1;
  logic [ID_W-1:0]           resp_id;
  logic [DATA_W-1:0]         resp_x, resp_y, resp_degree;
  logic                      busy;
`ifdef CORDIC_SCHED_STATS_EN
  logic [NUM_REQ*16-1:0]     stat_issued;
  logic [15:0]               stat_stall;
`endif

  always #5 clk = ~clk;

  cordic_req_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_angle(req_angle), .req_ready(req_ready),
    .pipe_degree_in(pipe_degree_in), .pipe_x(pipe_x), .pipe_y(pipe_y), .pipe_degree(pipe_degree),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_x(resp_x),
    .resp_y(resp_y), .resp_degree(resp_degree), .busy(busy)
`ifdef CORDIC_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  // Stub pipeline: 45 degrees returns the reference rotation, anything else a fixed scramble.
  function automatic logic [15:0] stub_x(input logic [15:0] a);
    return (a == 16'h2D00) ? 16'h00B5 : (a ^ 16'h5A5A);
  endfunction
  function automatic logic [15:0] stub_y(input logic [15:0] a);
    return (a == 16'h2D00) ? 16'h00B5 : (a + 16'h0101);
  endfunction

  logic [DATA_W-1:0] r_stub [LAT];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LAT; i++) r_stub[i] <= '0;
    end else begin
      r_stub[0] <= pipe_degree_in;
      for (int i = 1; i < LAT; i++) r_stub[i] <= r_stub[i-1];
    end
  end
  assign pipe_x      = stub_x(r_stub[LAT-1]);
  assign pipe_y      = stub_y(r_stub[LAT-1]);
  assign pipe_degree = r_stub[LAT-1];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard / protocol monitor, sampling 1 ns before each rising edge.
  typedef struct { int id; logic [15:0] angle; } exp_t;
  exp_t              exp_q[$];
  int                n_hs [NUM_REQ] = '{default: 0};
  int                n_blocked = 0;
  int                n_resp = 0;
  logic              prev_hold = 1'b0;
  logic [ID_W-1:0]   prev_id;
  logic [DATA_W-1:0] prev_x, prev_y, prev_d;

  always begin
    exp_t e;
    @(negedge clk); #4;
    if (!reset) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold valid", resp_valid, 1);
        check("hold id", resp_id, prev_id);
        check("hold x", resp_x, prev_x);
        check("hold y", resp_y, prev_y);
        check("hold degree", resp_degree, prev_d);
      end
      if (resp_valid && resp_ready) begin
        n_resp++;
        check("sb response expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb id", resp_id, e.id);
          check("sb x", resp_x, stub_x(e.angle));
          check("sb y", resp_y, stub_y(e.angle));
          check("sb degree", resp_degree, e.angle);
        end
      end
      for (int k = 0; k < NUM_REQ; k++) begin
        if (req_valid[k] && req_ready[k]) begin
          exp_q.push_back('{k, req_angle[k*DATA_W +: DATA_W]});
          n_hs[k]++;
        end
      end
      if ((|req_valid) && (req_ready == '0)) n_blocked++;
      if (|req_ready)
        check("grant legal", ($countones(req_ready) == 1) && ((req_ready & ~req_valid) == '0), 1);
      prev_hold = resp_valid && !resp_ready;
      prev_id   = resp_id;
      prev_x    = resp_x;
      prev_y    = resp_y;
      prev_d    = resp_degree;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset      = 1'b0;
    req_valid  = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drive_all(input int c);
    req_valid = '1;
    for (int k = 0; k < NUM_REQ; k++)
      req_angle[k*DATA_W +: DATA_W] = 16'(c * 256 + k * 16 + 1);
  endtask

  // Called at a sample point; returns there with busy low, or ok=0 on timeout.
  task automatic wait_idle(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (!busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #4;
    end
  endtask

  task automatic wait_valid(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      if (resp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #4;
    end
  endtask

  typedef struct {
    int          rid;
    logic [15:0] angle;
    logic [15:0] ex;
    logic [15:0] ey;
    logic [15:0] ed;
  } vec_t;

  initial begin
    vec_t vecs [5];
    bit   ok;
    int   lat, hs, hs0_base, blk_base, resp_base, hs_base;

    vecs[0] = '{2, 16'h2D00, 16'h00B5, 16'h00B5, 16'h2D00};
    vecs[1] = '{0, 16'h1E00, 16'h445A, 16'h1F01, 16'h1E00};
    vecs[2] = '{3, 16'h5A00, 16'h005A, 16'h5B01, 16'h5A00};
    vecs[3] = '{1, 16'h0000, 16'h5A5A, 16'h0101, 16'h0000};
    vecs[4] = '{2, 16'hFFFF, 16'hA5A5, 16'h0100, 16'hFFFF};

    // Reset state with requests already asserted.
    @(negedge clk);
    req_valid = '1;
    #1;
    check("reset req_ready", req_ready, 0);
    check("reset resp_valid", resp_valid, 0);
    check("reset busy", busy, 0);
    check("reset pipe_degree_in", pipe_degree_in, 0);
    check("reset resp_x", resp_x, 0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;

    // Single requests: grant, latency and returned data.
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      req_angle = '0;
      req_angle[vecs[v].rid*DATA_W +: DATA_W] = vecs[v].angle;
      req_valid = NUM_REQ'(1) << vecs[v].rid;
      #4;
      check($sformatf("v%0d grant", v), req_ready, NUM_REQ'(1) << vecs[v].rid);
      @(negedge clk);
      req_valid = '0;
      #4;
      check($sformatf("v%0d pipe_degree_in", v), pipe_degree_in, vecs[v].angle);
      lat = 0;
      while (!resp_valid && lat < 20) begin
        @(negedge clk); #4;
        lat++;
      end
      check($sformatf("v%0d latency", v), lat, LAT + 1);
      check($sformatf("v%0d resp_id", v), resp_id, vecs[v].rid);
      check($sformatf("v%0d resp_x", v), resp_x, vecs[v].ex);
      check($sformatf("v%0d resp_y", v), resp_y, vecs[v].ey);
      check($sformatf("v%0d resp_degree", v), resp_degree, vecs[v].ed);
    end

    // All requesters valid for 8 cycles: strict rotation, back-to-back responses.
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      drive_all(c);
      #4;
      check($sformatf("rr grant c%0d", c), req_ready, NUM_REQ'(1) << (c % NUM_REQ));
    end
    @(negedge clk);
    req_valid = '0;
    #4;
    wait_valid(20, ok);
    check("rr first response", ok, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rr resp_valid %0d", i), resp_valid, 1);
      check($sformatf("rr resp_id %0d", i), resp_id, i % NUM_REQ);
      @(negedge clk); #4;
    end

    // Backpressure fills the credits, then draining resumes issue in the first pop cycle.
    apply_reset();
    resp_ready = 1'b0;
    hs0_base   = n_hs[0];
    blk_base   = n_blocked;
    hs         = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      drive_all(c);
      #4;
      if (|req_ready) hs++;
      if (c >= DEPTH) check($sformatf("credit block c%0d", c), req_ready, 0);
    end
    check("credit handshakes", hs, DEPTH);
    check("credit fifo full valid", resp_valid, 1);
    for (int c = 20; c < 24; c++) begin
      @(negedge clk);
      resp_ready = 1'b1;
      drive_all(c);
      #4;
      check($sformatf("resume issue c%0d", c), |req_ready, 1);
      check($sformatf("resume pop c%0d", c), resp_valid, 1);
    end
    @(negedge clk);
    req_valid = '0;
    #4;
    wait_idle(60, ok);
    check("credit drain idle", ok, 1);
    check("credit req0 handshakes", n_hs[0] - hs0_base, 3);
    check("credit blocked cycles", n_blocked - blk_base, 12);
`ifdef CORDIC_SCHED_STATS_EN
    check("stat_issued[0]", stat_issued[15:0], n_hs[0] - hs0_base);
    check("stat_stall", stat_stall, n_blocked - blk_base);
`endif

    // Toggling resp_ready: held outputs stable, nothing lost or duplicated.
    apply_reset();
    hs_base   = n_hs[0] + n_hs[1] + n_hs[2] + n_hs[3];
    resp_base = n_resp;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      resp_ready = c[0];
      if (c < 24) drive_all(c + 100);
      else req_valid = '0;
    end
    @(negedge clk);
    resp_ready = 1'b1;
    #4;
    wait_idle(60, ok);
    check("toggle drain idle", ok, 1);
    check("toggle sb empty", exp_q.size(), 0);
    check("toggle resp count", n_resp - resp_base, n_hs[0] + n_hs[1] + n_hs[2] + n_hs[3] - hs_base);

    // Reset while three angles are in flight.
    apply_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive_all(c + 7);
    end
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset req_ready", req_ready, 0);
    check("midreset pipe_degree_in", pipe_degree_in, 0);
    check("midreset resp_valid", resp_valid, 0);
    check("midreset resp_id", resp_id, 0);
    check("midreset resp_x", resp_x, 0);
    check("midreset resp_y", resp_y, 0);
    check("midreset resp_degree", resp_degree, 0);
    check("midreset busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #4;
      check($sformatf("post-reset quiet c%0d", c), resp_valid, 0);
      check($sformatf("post-reset busy c%0d", c), busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete (time %0t)", $time);
    $fatal(1);
  end

endmodule
